// File: rtl/cwbp_pkg.sv
// Shared CWBP definitions: mapping-pointer field layout, terminator word,
// pointer encode helper and the writer FSM state type.
// Consumers: mapping_table_wr, cwbp_encoder, CWBP_Decoder.
package cwbp_pkg;

  // Mapping pointer layout: {way[3:0], row[27:0]}
  localparam int CWBP_WAY_MSB = 31;
  localparam int CWBP_WAY_LSB = 28;
  localparam int CWBP_WAY_W   = CWBP_WAY_MSB - CWBP_WAY_LSB + 1;
  localparam int CWBP_ROW_W   = 28;

  localparam logic [31:0] CWBP_END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } tbl_state_e;

  function automatic logic [31:0] cwbp_encode(input logic [CWBP_WAY_W-1:0] way,
                                              input logic [CWBP_ROW_W-1:0] row);
    return {way, row};
  endfunction

endpackage

// File: rtl/cwbp_encoder.sv
// Purpose: packs (way, row_address) into a CWBP mapping pointer and flags rows
// that do not fit in the 28-bit row field. Latency: combinational. Backpressure: none.
// Ports: way/row_address in; ptr (encoded word), row_ovf (row bits [31:28] non-zero) out.
module cwbp_encoder
  import cwbp_pkg::*;
(
  input  logic [CWBP_WAY_W-1:0] way,
  input  logic [31:0]           row_address,
  output logic [31:0]           ptr,
  output logic                  row_ovf
);

  assign ptr     = cwbp_encode(way, row_address[CWBP_ROW_W-1:0]);
  // The decoder zero-extends the row field, so any high bit would be silently lost.
  assign row_ovf = |row_address[31:CWBP_ROW_W];

endmodule

// File: rtl/mapping_table_wr.sv
// Purpose: writes a stream of CWBP pointers into the mapping-table BRAM, then an end marker.
// Latency: BRAM write strobe one cycle after each fire; table_done 3 cycles after the last fire.
// Backpressure: in_ready low during rst and while terminating a table (marker + done cycles).
// Ports: clk/rst; in_* entry stream (valid/ready); change_based_address bank select;
// err_clear; ram_* BRAM write port; busy, table_done, entry_count, err_row_overflow status.
module mapping_table_wr
  import cwbp_pkg::*;
#(
  parameter logic [31:0] START_ADDR  = 32'h4580_0000,
  parameter logic [31:0] BANK_STRIDE = 32'h0000_0100,
  parameter int          MAX_ENTRIES = 32,
  parameter logic [31:0] END_MARKER  = CWBP_END_MARKER,
  localparam int         CNT_W       = $clog2(MAX_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_way,
  input  logic [31:0]      in_row_address,
  input  logic             in_last,
  input  logic             change_based_address,
  input  logic             err_clear,
  output logic             ram_clk,
  output logic             ram_rst,
  output logic [31:0]      ram_addr,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [31:0]      ram_wd_data,
  output logic             busy,
  output logic             table_done,
  output logic [CNT_W-1:0] entry_count,
  output logic             err_row_overflow
);

  localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(MAX_ENTRIES - 1);

  tbl_state_e       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             bank_q, bank_d;
  logic             ram_en_q, ram_en_d;
  logic [3:0]       ram_we_q, ram_we_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wd_data_q, ram_wd_data_d;
  logic             table_done_q, table_done_d;
  logic [CNT_W-1:0] entry_count_q, entry_count_d;
  logic             err_q, err_d;

  logic             fire;
  logic             cur_bank;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] idx_next;
  logic [31:0]      slot_addr;
  logic [31:0]      enc_ptr;
  logic             enc_ovf;

  cwbp_encoder u_enc (
    .way         (in_way),
    .row_address (in_row_address),
    .ptr         (enc_ptr),
    .row_ovf     (enc_ovf)
  );

  // The first entry of a table uses the live bank select and slot 0; later slots
  // use the latched bank and running index.
  assign cur_bank  = (state_q == IDLE) ? change_based_address : bank_q;
  assign wr_idx    = (state_q == IDLE) ? '0 : idx_q;
  assign slot_addr = START_ADDR + (cur_bank ? BANK_STRIDE : 32'h0)
                   + {{(30-CNT_W){1'b0}}, wr_idx, 2'b00};
  assign idx_next  = enc_ovf ? wr_idx : wr_idx + IDX_ONE;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_d        = bank_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 4'h0;
    ram_addr_d    = ram_addr_q;
    ram_wd_data_d = ram_wd_data_q;
    table_done_d  = 1'b0;
    entry_count_d = entry_count_q;
    in_ready      = 1'b0;
    busy          = 1'b1;

    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        busy     = 1'b0;
      end
      FILL: begin
        in_ready = ~rst;
      end
      TERM: begin
        ram_en_d      = 1'b1;
        ram_we_d      = 4'hF;
        ram_addr_d    = slot_addr;
        ram_wd_data_d = END_MARKER;
        state_d       = DONE;
      end
      DONE: begin
        table_done_d  = 1'b1;
        entry_count_d = idx_q;
        idx_d         = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fire = in_valid & in_ready;

    if (fire) begin
      bank_d = cur_bank;
      idx_d  = idx_next;
      if (!enc_ovf) begin
        ram_en_d      = 1'b1;
        ram_we_d      = 4'hF;
        ram_addr_d    = slot_addr;
        ram_wd_data_d = enc_ptr;
      end
      // Leaving FILL as soon as only the marker slot remains drops in_ready
      // before another entry can be offered.
      state_d = (in_last || idx_next == IDX_LAST) ? TERM : FILL;
    end

    // Set wins over clear.
    err_d = (fire & enc_ovf) | (err_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      bank_q        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'h0;
      ram_addr_q    <= START_ADDR;
      ram_wd_data_q <= 32'h0;
      table_done_q  <= 1'b0;
      entry_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_q        <= bank_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wd_data_q <= ram_wd_data_d;
      table_done_q  <= table_done_d;
      entry_count_q <= entry_count_d;
      err_q         <= err_d;
    end
  end

  assign ram_clk          = clk;
  assign ram_rst          = rst;
  assign ram_addr         = ram_addr_q;
  assign ram_en           = ram_en_q;
  assign ram_we           = ram_we_q;
  assign ram_wd_data      = ram_wd_data_q;
  assign table_done       = table_done_q;
  assign entry_count      = entry_count_q;
  assign err_row_overflow = err_q;

endmodule

// File: tb/tb_mapping_table_wr.sv
// Purpose: self-checking bench for mapping_table_wr with a cycle-scheduled reference model.
// Latency: model schedules entry writes at fire+1, marker at close+2, done at close+3.
// Backpressure: stimulus waits (bounded) for in_ready before each entry.
module tb_mapping_table_wr;

  localparam int          MAXE   = 32;
  localparam logic [31:0] START  = 32'h4580_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0100;
  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, change_based_address, err_clear;
  logic [3:0]  in_way;
  logic [31:0] in_row_address;
  logic        ram_clk, ram_rst, ram_en, busy, table_done, err_row_overflow;
  logic [31:0] ram_addr, ram_wd_data;
  logic [3:0]  ram_we;
  logic [5:0]  entry_count;

  always #5 clk = ~clk;

  mapping_table_wr dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_way               (in_way),
    .in_row_address       (in_row_address),
    .in_last              (in_last),
    .change_based_address (change_based_address),
    .err_clear            (err_clear),
    .ram_clk              (ram_clk),
    .ram_rst              (ram_rst),
    .ram_addr             (ram_addr),
    .ram_en               (ram_en),
    .ram_we               (ram_we),
    .ram_wd_data          (ram_wd_data),
    .busy                 (busy),
    .table_done           (table_done),
    .entry_count          (entry_count),
    .err_row_overflow     (err_row_overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    int cyc;
    int cnt;
  } dn_t;

  wr_t wq[$];    // expected BRAM writes, by cycle
  dn_t dq[$];    // expected done pulses, by cycle
  wr_t wlog[$];  // observed writes for literal checks
  int  dlog[$];  // observed entry_count at each done pulse

  // Reference model state
  bit          mon_on  = 0;
  int          n       = 0;
  bit          m_open  = 0;
  bit          m_bank  = 0;
  int          m_idx   = 0;
  int          m_close = -100;
  int          m_count = 0;
  bit          m_err   = 0;
  bit          exp_ready, exp_busy, m_fire, m_rej;
  logic [31:0] m_base, m_ptr;

  always @(negedge clk) begin
    if (mon_on) begin
      exp_ready = !rst && !(n > m_close && n <= m_close + 2);
      exp_busy  = m_open || (n > m_close && n <= m_close + 2);
      check("in_ready", in_ready, exp_ready);
      check("busy", busy, exp_busy);

      if (wq.size() != 0 && wq[0].cyc == n) begin
        check("wr_en", ram_en, 1);
        check("wr_we", ram_we, 4'hF);
        check("wr_addr", ram_addr, wq[0].addr);
        check("wr_data", ram_wd_data, wq[0].data);
        void'(wq.pop_front());
      end else begin
        check("idle_en", ram_en, 0);
        check("idle_we", ram_we, 0);
      end
      if (ram_en) wlog.push_back('{n, ram_addr, ram_wd_data});

      if (dq.size() != 0 && dq[0].cyc == n) begin
        m_count = dq[0].cnt;
        check("done_pulse", table_done, 1);
        void'(dq.pop_front());
      end else begin
        check("done_idle", table_done, 0);
      end
      check("entry_count", entry_count, m_count);
      if (table_done) dlog.push_back(int'(entry_count));
      check("err_flag", err_row_overflow, m_err);

      if (rst) begin
        wq.delete();
        dq.delete();
        m_open  = 0;
        m_close = -100;
        m_count = 0;
        m_err   = 0;
      end else begin
        m_fire = in_valid && exp_ready;
        m_rej  = in_row_address >= 32'h1000_0000;
        if (m_fire) begin
          if (!m_open) begin
            m_open = 1;
            m_bank = change_based_address;
            m_idx  = 0;
          end
          m_base = START + (m_bank ? STRIDE : 32'h0);
          if (!m_rej) begin
            m_ptr = (32'(in_way) << 28) | (in_row_address & 32'h0FFF_FFFF);
            wq.push_back('{n + 1, m_base + 32'(m_idx * 4), m_ptr});
            m_idx++;
          end
          if (in_last || m_idx == MAXE - 1) begin
            m_open  = 0;
            m_close = n;
            wq.push_back('{n + 2, m_base + 32'(m_idx * 4), MARKER});
            dq.push_back('{n + 3, m_idx});
          end
        end
        m_err = (m_fire && m_rej) || (m_err && !err_clear);
      end
      n++;
    end
  end

  task automatic send(input logic [3:0] way, input logic [31:0] row, input logic last,
                      input logic cba, input logic clr);
    bit acc = 0;
    in_valid = 1; in_way = way; in_row_address = row; in_last = last;
    change_based_address = cba; err_clear = clr;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
    end
    check("accept_timeout", acc, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; err_clear = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input int i, input logic [31:0] addr, input logic [31:0] data);
    if (i < wlog.size()) begin
      check("log_addr", wlog[i].addr, addr);
      check("log_data", wlog[i].data, data);
    end else begin
      check("log_missing", 32'(wlog.size()), 32'(i + 1));
    end
  endtask

  task automatic check_done(input int cnt);
    if (dlog.size() == 1) check("log_count", 32'(dlog[0]), 32'(cnt));
    else check("log_ndone", 32'(dlog.size()), 1);
  endtask

  task automatic clear_logs();
    wlog.delete();
    dlog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_last = 0; in_way = 0; in_row_address = 0;
    change_based_address = 0; err_clear = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_addr", ram_addr, START);
    check("rst_data", ram_wd_data, 0);
    check("rst_en", ram_en, 0);
    check("rst_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", table_done, 0);
    check("rst_count", entry_count, 0);
    check("rst_err", err_row_overflow, 0);
    check("ram_rst", ram_rst, 1);
    check("ram_clk", ram_clk, clk);
    @(posedge clk); #1;
    rst = 0;
    mon_on = 1;
    idle(2);

    // Three entries, bank 0
    clear_logs();
    send(4'd1, 32'h10, 0, 0, 0);
    send(4'd2, 32'h20, 0, 0, 0);
    send(4'd3, 32'h30, 1, 0, 0);
    idle(5);
    check("t1_nwr", wlog.size(), 4);
    check_wr(0, 32'h4580_0000, 32'h1000_0010);
    check_wr(1, 32'h4580_0004, 32'h2000_0020);
    check_wr(2, 32'h4580_0008, 32'h3000_0030);
    check_wr(3, 32'h4580_000C, 32'hFFFF_FFFF);
    check_done(3);

    // Bank 1, bank select toggled mid-table
    clear_logs();
    send(4'd1, 32'h10, 0, 1, 0);
    send(4'd2, 32'h20, 0, 0, 0);
    send(4'd3, 32'h30, 1, 1, 0);
    idle(5);
    check("t2_nwr", wlog.size(), 4);
    check_wr(0, 32'h4580_0100, 32'h1000_0010);
    check_wr(1, 32'h4580_0104, 32'h2000_0020);
    check_wr(2, 32'h4580_0108, 32'h3000_0030);
    check_wr(3, 32'h4580_010C, 32'hFFFF_FFFF);
    check_done(3);

    // Rejected row between two valid entries
    clear_logs();
    send(4'd1, 32'h10, 0, 0, 0);
    send(4'd5, 32'h1000_0000, 0, 0, 0);
    send(4'd2, 32'h20, 1, 0, 0);
    idle(5);
    check("t3_nwr", wlog.size(), 3);
    check_wr(0, 32'h4580_0000, 32'h1000_0010);
    check_wr(1, 32'h4580_0004, 32'h2000_0020);
    check_wr(2, 32'h4580_0008, 32'hFFFF_FFFF);
    check_done(2);
    check("t3_err_sticky", err_row_overflow, 1);
    err_clear = 1;
    idle(1);
    err_clear = 0;
    check("t3_err_cleared", err_row_overflow, 0);
    idle(2);

    // Capacity: 31 entries fill the table, further offers are held off
    clear_logs();
    for (int i = 0; i < MAXE - 1; i++) send(i[3:0], 32'(i), 0, 0, 0);
    in_valid = 1; in_way = 4'hA; in_row_address = 32'h99;
    idle(2);
    in_valid = 0;
    idle(5);
    check("t4_nwr", wlog.size(), 32);
    check_wr(0, 32'h4580_0000, 32'h0000_0000);
    check_wr(17, 32'h4580_0044, 32'h1000_0011);
    check_wr(30, 32'h4580_0078, 32'hE000_001E);
    check_wr(31, 32'h4580_007C, 32'hFFFF_FFFF);
    check_done(31);

    // Reset in the middle of a table
    clear_logs();
    send(4'd4, 32'h40, 0, 1, 0);
    send(4'd5, 32'h50, 0, 1, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("t5_addr", ram_addr, START);
    check("t5_data", ram_wd_data, 0);
    check("t5_en", ram_en, 0);
    check("t5_busy", busy, 0);
    check("t5_count", entry_count, 0);
    idle(5);
    check("t5_nwr", wlog.size(), 2);
    check("t5_ndone", dlog.size(), 0);
    clear_logs();
    send(4'd7, 32'h55, 1, 0, 0);
    idle(5);
    check("t5b_nwr", wlog.size(), 2);
    check_wr(0, 32'h4580_0000, 32'h7000_0055);
    check_wr(1, 32'h4580_0004, 32'hFFFF_FFFF);
    check_done(1);

    // Empty table: lone rejected entry with last, error set while clear is held
    clear_logs();
    send(4'd9, 32'hF000_0001, 1, 0, 1);
    idle(5);
    check("t6_nwr", wlog.size(), 1);
    check_wr(0, 32'h4580_0000, 32'hFFFF_FFFF);
    check_done(0);
    check("t6_err", err_row_overflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mapping_table_wr.md
Name: mapping_table_wr

Overview:
- Writer side of the CWBP mapping-pointer table.
- Accepts (way, row_address) entries over a valid/ready stream, CWBP-encodes each into a 32-bit mapping pointer, and writes the words sequentially into the mapping-table BRAM.
- Appends an end marker after the last entry, then reports completion.
- Produces the table that base_address_rd fetches and CWBP_Decoder splits back into Way/Row_address.

Parameters:
- START_ADDR, 32'h4580_0000, BRAM byte address of bank 0 entry 0.
- BANK_STRIDE, 32'h0000_0100, byte offset between bank 0 and bank 1.
- MAX_ENTRIES, 32, table capacity in words per bank, including the end marker.
- END_MARKER, 32'hFFFF_FFFF, terminator word.

Ports:
- clk  in  1  single block clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  entry valid.
- in_ready  out  1  entry accept.
- in_way  in  4  flash way.
- in_row_address  in  32  row address.
- in_last  in  1  final entry of the table.
- change_based_address  in  1  bank select, sampled at the first entry of each table.
- err_clear  in  1  clears err_row_overflow.
- ram_clk  out  1  equals clk.
- ram_rst  out  1  equals rst.
- ram_addr  out  32  BRAM byte address.
- ram_en  out  1  BRAM enable.
- ram_we  out  4  byte write enables.
- ram_wd_data  out  32  encoded pointer or END_MARKER.
- busy  out  1  table in progress.
- table_done  out  1  one-cycle completion pulse.
- entry_count  out  $clog2(MAX_ENTRIES+1)  entries written in the last completed table.
- err_row_overflow  out  1  sticky error flag.

Behaviour:
- Encoding: pointer = {in_way[3:0], in_row_address[27:0]}. This is the exact inverse of CWBP_Decoder, which zero-extends bits [27:0].
- Fire: in_valid & in_ready.
- Entry rejection: a fired entry with in_row_address[31:28] != 0 is consumed but not written or counted, and err_row_overflow is set. The flag holds until rst or err_clear. If both set and clear occur in the same cycle, set wins.
- Registered outputs: all BRAM outputs are registered. The write strobe (ram_en=1, ram_we=4'hF) appears exactly one cycle after the fire and lasts one cycle. Otherwise ram_en=0, ram_we=0.
- Address: ram_addr = base + {idx, 2'b00}.
  - base = START_ADDR + (bank ? BANK_STRIDE : 0).
  - bank is latched from change_based_address at the first fire of a table and held until DONE.
- FSM IDLE:
  - in_ready=1, busy=0.
  - First fire: idx=0, latch bank, write the entry (if valid), go to FILL.
  - If that entry has in_last, go to TERM instead.
- FSM FILL:
  - in_ready=1, busy=1.
  - Each accepted valid entry increments idx after its write.
  - Go to TERM on a fire with in_last, or when idx reaches MAX_ENTRIES-1 (only the marker slot remains). In the capacity case in_ready drops in the same cycle, so no entry is lost.
- FSM TERM:
  - in_ready=0.
  - Writes END_MARKER at the current idx. Go to DONE.
- FSM DONE:
  - in_ready=0.
  - table_done=1 for exactly this cycle; entry_count is updated to idx. Go to IDLE.
- Empty table: if the only fired entry is rejected and carries in_last, the table has zero entries and the marker is written at idx 0.
- Reset values: state IDLE, idx 0, in_ready 0 during rst then 1, busy 0, table_done 0, entry_count 0, err_row_overflow 0, ram_en 0, ram_we 0, ram_addr START_ADDR, ram_wd_data 0.
- Reset mid-table: the partial table is abandoned. No marker and no table_done are produced.
- Throughput: one entry per cycle in FILL. Table latency from last fire to table_done is 3 cycles (entry write, marker write, done pulse).

Decomposition:
- Shared package cwbp_pkg holds:
  - CWBP_WAY_MSB=31, CWBP_WAY_LSB=28, CWBP_ROW_W=28.
  - END_MARKER default.
  - Function cwbp_encode(way,row).
  - FSM state enum {IDLE, FILL, TERM, DONE}.
- CWBP_Decoder should import the same field constants.
- One natural sub-module: cwbp_encoder (combinational encode plus overflow check), the mirror of CWBP_Decoder.

Test Plan:
- 3 entries (way 1/row 0x10, way 2/row 0x20, way 3/row 0x30 with last), bank 0 → writes 0x1000_0010 @0x4580_0000, 0x2000_0020 @0x4580_0004, 0x3000_0030 @0x4580_0008, END_MARKER @0x4580_000C; table_done pulse; entry_count=3.
- Same stream with change_based_address=1 at first fire, toggled mid-table → all writes at 0x4580_0100..0x4580_010C; the mid-table toggle is ignored.
- Entry row 0x1000_0000 between two valid entries → no write for it; err_row_overflow=1 and sticky; entry_count=2; err_clear → 0.
- 40 back-to-back entries, no last → 31 entries written at idx 0..30, END_MARKER at idx 31; in_ready drops after the 31st fire; entry_count=31.
- rst asserted in FILL after 2 entries → next cycle all outputs at reset values; no marker, no table_done; the next table restarts at idx 0.
- Single rejected entry with in_last → END_MARKER @0x4580_0000, entry_count=0, err_row_overflow=1.
